// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer.
//
// Fetch side presents a PC every cycle and receives a hit flag, a taken
// prediction and a predicted target, all combinational from stored state.
// Execute side writes one resolved branch/jump outcome per cycle through a
// single update port. Each entry holds valid, tag, target and a 2-bit
// saturating direction counter (0 strong NT .. 3 strong T).
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   BTB_fetch_pc      PC being fetched
//   BTB_hit           valid entry with matching tag
//   BTB_pred_taken    predicted taken (only with hit)
//   BTB_pred_target   predicted next PC, 0 on miss
//   BTB_upd_valid     update strobe from execute
//   BTB_upd_pc        PC of the resolved instruction
//   BTB_upd_target    resolved target
//   BTB_upd_taken     resolved direction (1 for jumps)
//   BTB_upd_is_jump   1 for jal/jalr, 0 for conditional branch
//   BTB_flush         invalidate all entries on the next edge

module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] BTB_fetch_pc,
    output logic        BTB_hit,
    output logic        BTB_pred_taken,
    output logic [31:0] BTB_pred_target,
    input  logic        BTB_upd_valid,
    input  logic [31:0] BTB_upd_pc,
    input  logic [31:0] BTB_upd_target,
    input  logic        BTB_upd_taken,
    input  logic        BTB_upd_is_jump,
    input  logic        BTB_flush
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    // Byte offset bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{BTB_fetch_pc[1:0], BTB_upd_pc[1:0]};

    // ---------------------------------------------------------------- lookup
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;

    assign fetch_idx = BTB_fetch_pc[IDX_W+1:2];
    assign fetch_tag = BTB_fetch_pc[31:IDX_W+2];

    always_comb begin
        BTB_hit         = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        BTB_pred_taken  = BTB_hit && ctr_q[fetch_idx][1];
        BTB_pred_target = BTB_hit ? target_q[fetch_idx] : 32'h0;
    end

    // ---------------------------------------------------------------- update
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             alloc;
    logic             hit_upd;
    logic             entry_we;
    logic             target_we;
    logic [1:0]       ctr_d;

    assign upd_idx = BTB_upd_pc[IDX_W+1:2];
    assign upd_tag = BTB_upd_pc[31:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        // Not-taken misses never allocate; flush discards any update.
        alloc     = BTB_upd_valid && !BTB_flush && !upd_hit && BTB_upd_taken;
        hit_upd   = BTB_upd_valid && !BTB_flush && upd_hit;
        entry_we  = alloc || hit_upd;
        target_we = alloc || (hit_upd && (BTB_upd_is_jump || BTB_upd_taken));

        ctr_d = ctr_q[upd_idx];
        if (alloc) begin
            ctr_d = BTB_upd_is_jump ? 2'd3 : 2'd2;
        end else if (BTB_upd_is_jump) begin
            ctr_d = 2'd3;
        end else if (BTB_upd_taken) begin
            ctr_d = (ctr_q[upd_idx] == 2'd3) ? 2'd3 : ctr_q[upd_idx] + 2'd1;
        end else begin
            ctr_d = (ctr_q[upd_idx] == 2'd0) ? 2'd0 : ctr_q[upd_idx] - 2'd1;
        end
    end

    // Only the valid bits carry reset; payload fields are qualified by valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else if (BTB_flush) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (entry_we) begin
            ctr_q[upd_idx] <= ctr_d;
            if (alloc) begin
                tag_q[upd_idx] <= upd_tag;
            end
            if (target_we) begin
                target_q[upd_idx] <= BTB_upd_target;
            end
        end
    end

endmodule
